// File: rtl/pll_reconfig_ctl.sv
// Run-time PLL retuning sequencer driving the Altera PLL reconfiguration Avalon-MM port.
// Optional fractional K write is enabled by defining PLL_RECONFIG_FRAC_EN.
module pll_reconfig_ctl #(
  parameter logic [15:0] LOCK_TIMEOUT = 16'd50000,
  parameter logic [3:0]  POLL_GAP     = 4'd8
) (
  input  logic        refclk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [17:0] cfg_n,
  input  logic [17:0] cfg_m,
  input  logic [17:0] cfg_c,
  input  logic [4:0]  cfg_c_sel,
`ifdef PLL_RECONFIG_FRAC_EN
  input  logic [31:0] cfg_k,
`endif
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic        mgmt_read,
  output logic [31:0] mgmt_writedata,
  input  logic [31:0] mgmt_readdata,
  input  logic        mgmt_waitrequest,
  input  logic        pll_locked
);

  typedef enum logic [3:0] {
    IDLE,
    W_MODE,
    W_N,
    W_M,
`ifdef PLL_RECONFIG_FRAC_EN
    W_K,
`endif
    W_C,
    W_START,
    POLL,
    GAP,
    LOCK_WAIT,
    DONE,
    ERR
  } state_t;

  state_t      state_reg, state_next;
  logic [17:0] n_reg, m_reg, c_reg;
  logic [4:0]  c_sel_reg;
`ifdef PLL_RECONFIG_FRAC_EN
  logic [31:0] k_reg;
`endif
  logic [15:0] tmo_cnt_reg, tmo_cnt_next, tmo_inc;
  logic [3:0]  gap_cnt_reg, gap_cnt_next;
  logic        timed_out, xfer_ok, accept;

  logic        busy_next, done_next, error_next, write_next, read_next;
  logic [5:0]  addr_next;
  logic [31:0] data_next;

  // Only the status bit of the readback is meaningful.
  logic unused_readdata;
  assign unused_readdata = ^mgmt_readdata[31:1];

  assign accept    = (state_reg == IDLE) && req;
  assign xfer_ok   = !mgmt_waitrequest;
  assign tmo_inc   = (tmo_cnt_reg == 16'hFFFF) ? tmo_cnt_reg : tmo_cnt_reg + 16'd1;
  // Timeout fires on the edge where the count lands on LOCK_TIMEOUT.
  assign timed_out = (tmo_inc >= LOCK_TIMEOUT);

  always_comb begin
    state_next   = state_reg;
    tmo_cnt_next = tmo_cnt_reg;
    gap_cnt_next = gap_cnt_reg;
    case (state_reg)
      IDLE:   if (req) state_next = W_MODE;
      W_MODE: if (xfer_ok) state_next = W_N;
      W_N:    if (xfer_ok) state_next = W_M;
`ifdef PLL_RECONFIG_FRAC_EN
      W_M:    if (xfer_ok) state_next = W_K;
      W_K:    if (xfer_ok) state_next = W_C;
`else
      W_M:    if (xfer_ok) state_next = W_C;
`endif
      W_C: begin
        if (xfer_ok) begin
          state_next   = W_START;
          tmo_cnt_next = 16'd0;
        end
      end
      W_START: begin
        tmo_cnt_next = tmo_inc;
        if (timed_out)    state_next = ERR;
        else if (xfer_ok) state_next = POLL;
      end
      POLL: begin
        tmo_cnt_next = tmo_inc;
        if (timed_out) begin
          state_next = ERR;
        end else if (xfer_ok) begin
          if (mgmt_readdata[0]) begin
            state_next = LOCK_WAIT;
          end else begin
            state_next   = GAP;
            gap_cnt_next = 4'd0;
          end
        end
      end
      GAP: begin
        tmo_cnt_next = tmo_inc;
        if (timed_out) begin
          state_next = ERR;
        end else if (({1'b0, gap_cnt_reg} + 5'd1) >= {1'b0, POLL_GAP}) begin
          state_next = POLL;
        end else begin
          gap_cnt_next = gap_cnt_reg + 4'd1;
        end
      end
      LOCK_WAIT: begin
        tmo_cnt_next = tmo_inc;
        if (pll_locked)     state_next = DONE;
        else if (timed_out) state_next = ERR;
      end
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet aligned with it.
  always_comb begin
    busy_next  = (state_next != IDLE);
    done_next  = (state_next == DONE);
    error_next = error;
    if (accept)              error_next = 1'b0;
    if (state_next == ERR)   error_next = 1'b1;
    write_next = 1'b0;
    read_next  = 1'b0;
    addr_next  = 6'd0;
    data_next  = 32'd0;
    case (state_next)
      W_MODE: begin
        write_next = 1'b1;
        addr_next  = 6'd0;
        data_next  = 32'd0;
      end
      W_N: begin
        write_next = 1'b1;
        addr_next  = 6'd3;
        data_next  = {14'd0, n_reg};
      end
      W_M: begin
        write_next = 1'b1;
        addr_next  = 6'd4;
        data_next  = {14'd0, m_reg};
      end
`ifdef PLL_RECONFIG_FRAC_EN
      W_K: begin
        write_next = 1'b1;
        addr_next  = 6'd7;
        data_next  = k_reg;
      end
`endif
      W_C: begin
        write_next = 1'b1;
        addr_next  = 6'd5;
        data_next  = {9'd0, c_sel_reg, c_reg};
      end
      W_START: begin
        write_next = 1'b1;
        addr_next  = 6'd2;
        data_next  = 32'd1;
      end
      POLL: begin
        read_next = 1'b1;
        addr_next = 6'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      n_reg          <= '0;
      m_reg          <= '0;
      c_reg          <= '0;
      c_sel_reg      <= '0;
`ifdef PLL_RECONFIG_FRAC_EN
      k_reg          <= '0;
`endif
      tmo_cnt_reg    <= '0;
      gap_cnt_reg    <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      mgmt_write     <= 1'b0;
      mgmt_read      <= 1'b0;
      mgmt_address   <= '0;
      mgmt_writedata <= '0;
    end else begin
      state_reg   <= state_next;
      tmo_cnt_reg <= tmo_cnt_next;
      gap_cnt_reg <= gap_cnt_next;
      if (accept) begin
        n_reg     <= cfg_n;
        m_reg     <= cfg_m;
        c_reg     <= cfg_c;
        c_sel_reg <= cfg_c_sel;
`ifdef PLL_RECONFIG_FRAC_EN
        k_reg     <= cfg_k;
`endif
      end
      busy           <= busy_next;
      done           <= done_next;
      error          <= error_next;
      mgmt_write     <= write_next;
      mgmt_read      <= read_next;
      mgmt_address   <= addr_next;
      mgmt_writedata <= data_next;
    end
  end

endmodule

// File: doc/pll_reconfig_ctl.md
# pll_reconfig_ctl

Sequencer that reprograms the on-chip general-purpose PLL at run time through the Altera PLL reconfiguration Avalon-MM management port. Sits between the video-mode/clock-select logic and the `pll_reconfig` slave attached to the 50 MHz-referenced PLL, so that an output clock such as the pixel clock can be retuned without a bitstream reload. One request writes the mode, N, M and one C counter, triggers the update, polls for completion and waits for PLL lock, with a bounded timeout.

## Interface
Parameters:
- `LOCK_TIMEOUT`, 16'd50000: cycles allowed from START write to completion of status poll plus `pll_locked` high.
- `POLL_GAP`, 4'd8: idle cycles between successive status reads.

Ports:
- `refclk` in 1: management clock, the PLL's 50 MHz reference; the only clock.
- `rst_n` in 1: synchronous, active-low reset.
- `req` in 1: level sampled in IDLE; a high sample starts a reconfiguration.
- `cfg_n` in 18: N counter word {bypass, odd, high[7:0], low[7:0]}.
- `cfg_m` in 18: M counter word, same format.
- `cfg_c` in 18: C counter word, same format.
- `cfg_c_sel` in 5: C counter index, 0..17.
- `busy` out 1: high from the accepted request through DONE/ERR.
- `done` out 1: one-cycle pulse on successful completion.
- `error` out 1: sticky timeout flag; cleared on next accepted request.
- `mgmt_address` out 6, `mgmt_write` out 1, `mgmt_read` out 1, `mgmt_writedata` out 32: Avalon-MM master.
- `mgmt_readdata` in 32, `mgmt_waitrequest` in 1: Avalon-MM slave response.
- `pll_locked` in 1: PLL lock, already synchronised to `refclk`.

## Operation
- Request acceptance: in IDLE with `req`=1, all `cfg_*` inputs are captured into registers, `error` is cleared, and the FSM enters W_MODE. `req` is ignored while `busy`=1.
- Write states, in order:
  - W_MODE: addr 0, data 0 (waitrequest mode).
  - W_N: addr 3, data {14'b0, n}.
  - W_M: addr 4, data {14'b0, m}.
  - [W_K, see Configuration.]
  - W_C: addr 5, data {9'b0, c_sel, c}.
  - W_START: addr 2, data 1.
- Each write holds `mgmt_write`, address and data stable until a cycle with `mgmt_waitrequest`=0. That cycle completes the transfer and the FSM advances on the next edge.
- POLL:
  - Issues a read of addr 1, holding `mgmt_read` until `mgmt_waitrequest`=0, then samples `mgmt_readdata[0]`.
  - If the bit is 0: waits `POLL_GAP` cycles in GAP, then reads again.
  - If the bit is 1: goes to LOCK_WAIT.
- LOCK_WAIT: `pll_locked`=1 moves the FSM to DONE.
- Timeout: a 16-bit counter clears on entry to W_START and increments every cycle in W_START, POLL, GAP and LOCK_WAIT. Reaching `LOCK_TIMEOUT` in any of these states moves the FSM to ERR.
- DONE: `done`=1 for one cycle, then IDLE.
- ERR: sets `error`, then IDLE.
- `busy` is high in every state except IDLE.
- Simultaneous events: if the counter reaches `LOCK_TIMEOUT` in the same cycle as `pll_locked`=1, the lock wins and the FSM goes to DONE.

## Timing
- Reset (`rst_n`=0 at an edge) forces IDLE at that edge and clears all outputs:
  - `busy`, `done`, `error`, `mgmt_write`, `mgmt_read` = 0.
  - `mgmt_address` = 0, `mgmt_writedata` = 0.
- Reset mid-transfer drops the strobes immediately; the PLL must be reset externally afterwards.
- Zero-wait-state slave:
  - Each write is 1 cycle.
  - Accepted `req` to the first `mgmt_write` is 1 cycle.
  - Status bit sampled 1 to `done` is 1 cycle after `pll_locked` is seen high.
- `mgmt_write` and `mgmt_read` are never high together. All outputs are registered.
- The counter saturates and does not wrap.

## Configuration
- `PLL_RECONFIG_FRAC_EN`:
  - Defined: adds input `cfg_k` (32 bits), captured with the other `cfg_*` inputs, and state W_K between W_M and W_C, writing addr 7 with data `cfg_k`.
  - Undefined: no `cfg_k` port and no W_K state; W_M goes directly to W_C.

## Test plan
- Zero-wait slave, status=1 on first read, `pll_locked` high; `req` with n=18'h00505, m=18'h00808, c_sel=1, c=18'h20202 -> writes in order (0,0), (3,0x505), (4,0x808), (5,0x60202), (2,1); one read of addr 1; `done` pulses once; `busy` low the next cycle.
- Slave holds waitrequest high for 3 cycles on each write -> each write is held 4 cycles with stable address/data; same final result.
- Status bit returns 0 for 2 reads, then 1 -> 3 reads spaced by 8 idle cycles; `done` pulses.
- `pll_locked` never rises, `LOCK_TIMEOUT`=100 -> `error`=1 exactly 100 cycles after W_START entry and `done` stays 0; the next `req` clears `error`.
- `rst_n` pulsed low during W_M with waitrequest high -> all outputs 0 on the next edge, FSM in IDLE; a new `req` restarts at W_MODE.
- With `PLL_RECONFIG_FRAC_EN` defined and `cfg_k`=32'h80000000 -> write (7,0x80000000) appears between the addr-4 and addr-5 writes.
